// File: rtl/pe_8ip_ctrl_seq_if.sv
// rtl/pe_8ip_ctrl_seq_if.sv - scheduler command handshake and PE_8IP control bundle
interface pe_8ip_ctrl_seq_if;
    logic        start;
    logic        cmd_use_int;
    logic        cmd_l1_sub;
    logic        abort;
    logic [31:0] pe_out;
    logic [19:0] io_m_sel;
    logic [1:0]  io_addsub_0_op;
    logic [1:0]  io_addsub_1_op;
    logic        io_use_int;
    logic [2:0]  io_rounding;
    logic        io_tininess;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, cmd_use_int, cmd_l1_sub, abort, pe_out,
        input  io_m_sel, io_addsub_0_op, io_addsub_1_op, io_use_int,
               io_rounding, io_tininess, busy, done, result
    );

    modport slave (
        input  start, cmd_use_int, cmd_l1_sub, abort, pe_out,
        output io_m_sel, io_addsub_0_op, io_addsub_1_op, io_use_int,
               io_rounding, io_tininess, busy, done, result
    );
endinterface

// File: rtl/pe_8ip_ctrl_seq.sv
// rtl/pe_8ip_ctrl_seq.sv - three-phase PE_8IP control sequencer (L1, aggregation, drain)
module pe_8ip_ctrl_seq #(
    parameter int L1_CYCLES    = 30,
    parameter int AGGR_CYCLES  = 76,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input logic                clock,
    input logic                reset,
    pe_8ip_ctrl_seq_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, L1, AGGR, STOP, DONE} state_t;

    // Two select bits per mux: m0-3 in [7:0], m4-7 in [15:8], m8-9 in [19:16]
    localparam logic [19:0] SEL_IDLE = 20'hAFFFF;
    localparam logic [19:0] SEL_L1   = 20'h00055;
    localparam logic [19:0] SEL_AGGR = 20'h0AA55;

    localparam logic [CNT_W-1:0] L1_LOAD    = CNT_W'(L1_CYCLES - 1);
    localparam logic [CNT_W-1:0] AGGR_LOAD  = CNT_W'(AGGR_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    assign bus.io_tininess = 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            bus.io_m_sel       <= SEL_IDLE;
            bus.io_addsub_0_op <= 2'b00;
            bus.io_addsub_1_op <= 2'b00;
            bus.io_use_int     <= 1'b0;
            bus.io_rounding    <= 3'b100;
            bus.result         <= 32'h0;
            bus.done           <= 1'b0;
            bus.busy           <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state              <= L1;
                        cnt                <= L1_LOAD;
                        bus.busy           <= 1'b1;
                        bus.io_m_sel       <= SEL_L1;
                        bus.io_addsub_0_op <= {1'b0, bus.cmd_l1_sub};
                        bus.io_addsub_1_op <= {1'b0, bus.cmd_l1_sub};
                        bus.io_use_int     <= bus.cmd_use_int;
                        bus.io_rounding    <= bus.cmd_use_int ? 3'b111 : 3'b100;
                    end
                end
                L1, AGGR, STOP: begin
                    // Abort takes priority over a phase ending on the same edge
                    if (bus.abort) begin
                        state              <= IDLE;
                        cnt                <= '0;
                        bus.busy           <= 1'b0;
                        bus.io_m_sel       <= SEL_IDLE;
                        bus.io_addsub_0_op <= 2'b00;
                        bus.io_addsub_1_op <= 2'b00;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (state == L1) begin
                        state              <= AGGR;
                        cnt                <= AGGR_LOAD;
                        bus.io_m_sel       <= SEL_AGGR;
                        bus.io_addsub_0_op <= 2'b00;
                        bus.io_addsub_1_op <= 2'b00;
                    end else if (state == AGGR) begin
                        state        <= STOP;
                        cnt          <= DRAIN_LOAD;
                        bus.io_m_sel <= SEL_IDLE;
                    end else begin
                        state      <= DONE;
                        bus.result <= bus.pe_out;
                        bus.done   <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pe_8ip_ctrl_seq.sv
// tb/tb_pe_8ip_ctrl_seq.sv - directed bench for pe_8ip_ctrl_seq (default and all-ones phase lengths)
module tb_pe_8ip_ctrl_seq;
    logic clock = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   total = 0;
    int   bad   = 0;

    localparam logic [19:0] S_IDLE = 20'hAFFFF;
    localparam logic [19:0] S_L1   = 20'h00055;
    localparam logic [19:0] S_AGGR = 20'h0AA55;

    always #5 clock = ~clock;

    pe_8ip_ctrl_seq_if a ();
    pe_8ip_ctrl_seq_if b ();

    pe_8ip_ctrl_seq dut_a (.clock(clock), .reset(rst_a), .bus(a.slave));

    pe_8ip_ctrl_seq #(.L1_CYCLES(1), .AGGR_CYCLES(1), .DRAIN_CYCLES(1), .CNT_W(2)) dut_b (
        .clock(clock), .reset(rst_b), .bus(b.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One command on dut_a; k counts edges after the start edge.
    // poke_k >= 0 pulses abort (poke_abort=1) or start (0) at that sample point.
    task automatic run_a(input string tag, input logic ui, input logic sub, input logic [31:0] pv,
                         input int poke_k, input logic poke_abort, input logic start_abort,
                         input logic [31:0] res_before);
        int n_done = 0, done_k = -1, sel_bad = 0, op_bad = 0, busy_bad = 0, mode_bad = 0;
        logic [19:0] es;
        logic [1:0]  eo;
        logic        eb;
        logic        aborted = 1'b0;
        a.cmd_use_int = ui;
        a.cmd_l1_sub  = sub;
        a.pe_out      = pv;
        a.start       = 1'b1;
        a.abort       = start_abort;
        step();
        a.start       = 1'b0;
        a.abort       = 1'b0;
        a.cmd_use_int = ~ui;
        a.cmd_l1_sub  = ~sub;
        for (int k = 0; k < 120; k++) begin
            if (aborted)      begin es = S_IDLE; eo = 2'b00;        eb = 1'b0; end
            else if (k < 30)  begin es = S_L1;   eo = {1'b0, sub};  eb = 1'b1; end
            else if (k < 106) begin es = S_AGGR; eo = 2'b00;        eb = 1'b1; end
            else if (k < 109) begin es = S_IDLE; eo = 2'b00;        eb = 1'b1; end
            else              begin es = S_IDLE; eo = 2'b00;        eb = 1'b0; end
            if (a.io_m_sel !== es) sel_bad++;
            if (a.io_addsub_0_op !== eo || a.io_addsub_1_op !== eo) op_bad++;
            if (a.busy !== eb) busy_bad++;
            if (a.io_use_int !== ui || a.io_rounding !== (ui ? 3'b111 : 3'b100)) mode_bad++;
            if (a.done === 1'b1) begin n_done++; done_k = k; end
            if (k == poke_k) begin
                if (poke_abort) a.abort = 1'b1;
                else            a.start = 1'b1;
            end
            step();
            a.abort = 1'b0;
            a.start = 1'b0;
            if (k == poke_k && poke_abort) aborted = 1'b1;
        end
        check({tag, "_sel"}, sel_bad, 0);
        check({tag, "_ops"}, op_bad, 0);
        check({tag, "_busy"}, busy_bad, 0);
        check({tag, "_mode"}, mode_bad, 0);
        check({tag, "_ndone"}, n_done, (poke_k >= 0 && poke_abort) ? 0 : 1);
        if (!(poke_k >= 0 && poke_abort)) check({tag, "_done_k"}, done_k, 108);
        check({tag, "_result"}, a.result, (poke_k >= 0 && poke_abort) ? res_before : pv);
    endtask

    initial begin
        int n_done;
        logic [19:0] b_sel [5] = '{S_L1, S_AGGR, S_IDLE, S_IDLE, S_IDLE};
        logic        b_busy[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        b_done[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        {a.start, a.cmd_use_int, a.cmd_l1_sub, a.abort} = 4'b0;
        {b.start, b.cmd_use_int, b.cmd_l1_sub, b.abort} = 4'b0;
        a.pe_out = 32'h0;
        b.pe_out = 32'h0;
        step();
        step();
        check("rst_sel", a.io_m_sel, S_IDLE);
        check("rst_op0", a.io_addsub_0_op, 0);
        check("rst_op1", a.io_addsub_1_op, 0);
        check("rst_use_int", a.io_use_int, 0);
        check("rst_rounding", a.io_rounding, 3'b100);
        check("rst_tininess", a.io_tininess, 1);
        check("rst_result", a.result, 0);
        check("rst_done", a.done, 0);
        check("rst_busy", a.busy, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        step();

        run_a("int",      1'b1, 1'b1, 32'hFFFFFF00, -1, 1'b0, 1'b0, 32'h0);
        run_a("fp",       1'b0, 1'b1, 32'hC3800000, -1, 1'b0, 1'b0, 32'h0);
        run_a("busy_st",  1'b1, 1'b0, 32'h12345678, 49, 1'b0, 1'b0, 32'h0);
        run_a("abort",    1'b0, 1'b0, 32'hDEADBEEF, 59, 1'b1, 1'b0, 32'h12345678);
        run_a("st_abort", 1'b1, 1'b1, 32'h0BADF00D, -1, 1'b0, 1'b1, 32'h0);

        // Asynchronous reset between edges while in L1
        a.cmd_use_int = 1'b1;
        a.start = 1'b1;
        step();
        a.start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        #3 rst_a = 1'b1;
        #1;
        check("arst_sel", a.io_m_sel, S_IDLE);
        check("arst_busy", a.busy, 0);
        check("arst_result", a.result, 0);
        check("arst_use_int", a.io_use_int, 0);
        check("arst_rounding", a.io_rounding, 3'b100);
        check("arst_ops", {a.io_addsub_0_op, a.io_addsub_1_op}, 0);
        step();
        step();
        rst_a = 1'b0;
        n_done = 0;
        for (int i = 0; i < 120; i++) begin
            if (a.done === 1'b1 || a.busy === 1'b1) n_done++;
            step();
        end
        check("arst_no_done", n_done, 0);

        // All phases one cycle long
        b.pe_out = 32'hA5A5_0001;
        b.start = 1'b1;
        step();
        b.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("b_sel%0d", k), b.io_m_sel, b_sel[k]);
            check($sformatf("b_busy%0d", k), b.busy, b_busy[k]);
            check($sformatf("b_done%0d", k), b.done, b_done[k]);
            step();
        end
        check("b_result", b.result, 32'hA5A5_0001);

        // Abort on the L1->AGGR edge
        b.pe_out = 32'h7777_7777;
        b.start = 1'b1;
        step();
        b.start = 1'b0;
        b.abort = 1'b1;
        step();
        b.abort = 1'b0;
        check("b_ab_sel", b.io_m_sel, S_IDLE);
        check("b_ab_busy", b.busy, 0);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (b.done === 1'b1) n_done++;
            step();
        end
        check("b_ab_no_done", n_done, 0);
        check("b_ab_result", b.result, 32'hA5A5_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pe_8ip_ctrl_seq.md
Name: pe_8ip_ctrl_seq

Overview:
- Hardware control sequencer that drives the PE_8IP control interface: mux selects, add/sub ops, number format and rounding.
- Runs one command as three phases: L1 (element-wise multiply/sub), aggregation, then a stop/drain phase. At the end it captures the PE result.
- Sits between the layer scheduler (start/abort/done handshake) and one PE_8IP instance.
- Replaces the bench-driven control sequence with synthesizable control.

Parameters:
- L1_CYCLES, 30, cycles spent in the L1 phase (>=1).
- AGGR_CYCLES, 76, cycles spent in the aggregation phase (>=1).
- DRAIN_CYCLES, 2, cycles in the stop phase before result capture (>=1).
- CNT_W, 8, phase counter width; must hold max(L1_CYCLES, AGGR_CYCLES, DRAIN_CYCLES)-1.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command request, sampled only in IDLE.
- cmd_use_int  in  1  1 = INT32, 0 = FP32; latched on accepted start.
- cmd_l1_sub  in  1  L1 add/sub op (1 = "-"); latched on accepted start.
- abort  in  1  synchronous cancel of a running command.
- pe_out  in  32  PE io_out.
- io_m_sel  out  20  mux selects; mux i uses bits [2i+1:2i], i = 0..9.
- io_addsub_0_op  out  2  add/sub op for adder 0.
- io_addsub_1_op  out  2  add/sub op for adder 1.
- io_use_int  out  1  number format to PE.
- io_rounding  out  3  rounding mode to PE.
- io_tininess  out  1  constant 1.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse, result valid.
- result  out  32  captured pe_out; held until the next capture.

Behaviour:
- Reset (async, active-high) forces:
  - state = IDLE, counter = 0.
  - Selects at idle values; addsub ops = 0.
  - io_use_int = 0, io_rounding = 3'b100.
  - result = 0, done = 0, busy = 0.
  - Reset mid-command discards everything; no done is produced.
- Every output is registered. Selects, ops and mode are stable for the full duration of each phase.
- Select encoding per phase (m0-3 / m4-7 / m8-9):
  - IDLE / STOP: 3 / 3 / 2.
  - L1: 1 / 0 / 0.
  - AGGR: 1 / 2 / 0.
- Add/sub ops per phase:
  - L1: both ops = {1'b0, l1_sub}.
  - AGGR, STOP, IDLE: both ops = 0.
- Mode outputs:
  - io_use_int = latched cmd_use_int.
  - io_rounding = 3'b111 if INT, 3'b100 if FP.
  - Both update at start acceptance and hold through IDLE until the next accepted start.
- FSM transitions:
  - IDLE: start=1 -> latch cmd, go to L1, counter = L1_CYCLES-1. start is ignored in every other state; there is no queueing.
  - L1: counter decrements each cycle. At 0 -> AGGR, counter = AGGR_CYCLES-1.
  - AGGR: at 0 -> STOP, counter = DRAIN_CYCLES-1.
  - STOP: at 0 -> result <= pe_out on that edge, then go to DONE.
  - DONE: done = 1 for exactly one cycle, busy = 1, then IDLE.
- Latency: start sampled at edge T.
  - L1 outputs are visible from cycle T+1.
  - done is high in cycle T+1+L1_CYCLES+AGGR_CYCLES+DRAIN_CYCLES; with defaults this is T+109.
  - The next start is accepted no earlier than the cycle after done.
- Abort:
  - In L1, AGGR or STOP: next state = IDLE with idle selects. No done, result unchanged.
  - In IDLE or DONE: ignored; the done pulse still completes.
- Simultaneous events:
  - abort and a counter reaching 0 in the same cycle: abort wins.
  - abort and start in IDLE: start is accepted and abort is ignored.
- No arithmetic on data; pe_out is captured verbatim.

Test Plan:
- INT command: reset, then start with cmd_use_int=1, cmd_l1_sub=1; pe_out stub = 0xFFFFFF00 in STOP.
  - io_m_sel = 0x00055 during L1 cycles 1-30 and 0x0AA55 during the 76 AGGR cycles.
  - addsub ops = 2'b01 in L1.
  - io_rounding = 3'b111.
  - done at cycle 109, result = 0xFFFFFF00.
- FP command: start with cmd_use_int=0, cmd_l1_sub=1; pe_out = 0xC3800000.
  - io_use_int = 0, io_rounding = 3'b100.
  - done 109 cycles after start, result = 0xC3800000.
  - busy low the cycle after done.
- Start while busy: pulse start at cycle 50 of a running command -> no restart; a single done at 109; latched mode unchanged.
- Abort in AGGR at cycle 60 -> IDLE next cycle, io_m_sel = 0xAFFFF, no done, result keeps its previous value; a fresh start then completes normally.
- Async reset asserted mid-L1 between clock edges -> outputs go to reset values immediately; result = 0, done never pulses.
- Boundary: L1_CYCLES = AGGR_CYCLES = DRAIN_CYCLES = 1 -> one cycle each of L1/AGGR/STOP; done at T+4.
  - Same configuration with abort coinciding with the L1->AGGR transition -> abort wins, state goes to IDLE.
